// File: rtl/simmem_write_responder.sv
// simmem_write_responder
// Slave-side AXI write responder for the simulated memory. AW requests are
// queued in a small FIFO. W beats are counted against the head burst and are
// never stored. One B response is produced per completed burst, in the order
// the AW requests were accepted.
module simmem_write_responder #(
    parameter int unsigned IDWidth      = 4,
    parameter int unsigned AxLenWidth   = 8,
    parameter int unsigned XRespWidth   = 3,
    parameter int unsigned AwQueueDepth = 4,
    parameter int unsigned RespOkay     = 0,
    parameter int unsigned RespSlvErr   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [IDWidth-1:0]    aw_id_i,
    input  logic [AxLenWidth-1:0] aw_len_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic                  w_last_i,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic [IDWidth-1:0]    b_id_o,
    output logic [XRespWidth-1:0] b_content_o
);

    localparam int unsigned PtrW = $clog2(AwQueueDepth);
    localparam int unsigned CntW = PtrW + 1;

    // A burst is well formed only when the last flag lands exactly on beat len.
    function automatic logic [XRespWidth-1:0] resp_content(input logic last,
                                                           input logic at_len);
        return (last && at_len) ? XRespWidth'(RespOkay) : XRespWidth'(RespSlvErr);
    endfunction

    // AW queue storage and control
    logic [IDWidth-1:0]    id_mem  [AwQueueDepth];
    logic [AxLenWidth-1:0] len_mem [AwQueueDepth];
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [CntW-1:0]       count_q;
    logic [CntW-1:0]       count_next;
    logic                  full_q;
    logic                  empty;

    // Head-burst beat tracking
    logic [AxLenWidth-1:0] beat_q;
    logic [IDWidth-1:0]    head_id;
    logic [AxLenWidth-1:0] head_len;
    logic                  at_len;

    // Handshakes
    logic                  push;
    logic                  w_hs;
    logic                  burst_end;
    logic                  b_hs;

    // B response register
    logic                  b_vld_p1;
    logic [IDWidth-1:0]    b_id_p1;
    logic [XRespWidth-1:0] b_content_p1;

    assign empty      = (count_q == '0);
    assign head_id    = id_mem[rd_ptr_q];
    assign head_len   = len_mem[rd_ptr_q];
    assign at_len     = (beat_q == head_len);

    // aw_ready comes straight from a register, so a same-cycle pop never
    // opens a slot for a same-cycle push.
    assign aw_ready_o = !full_q;
    assign push       = aw_valid_i && !full_q;

    // A beat is only taken when a burst is pending and the B slot can be
    // refilled on the same edge.
    assign w_ready_o  = !empty && (!b_vld_p1 || b_ready_i);
    assign w_hs       = w_valid_i && w_ready_o;
    assign burst_end  = w_hs && (w_last_i || at_len);
    assign b_hs       = b_vld_p1 && b_ready_i;

    assign b_valid_o   = b_vld_p1;
    assign b_id_o      = b_id_p1;
    assign b_content_o = b_content_p1;

    // Next occupancy: a simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count_q;
        case ({push, burst_end})
            2'b10:   count_next = count_q + CntW'(1);
            2'b01:   count_next = count_q - CntW'(1);
            default: count_next = count_q;
        endcase
    end

    // Queue payload write; storage is data only and needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr_q]  <= aw_id_i;
            len_mem[wr_ptr_q] <= aw_len_i;
        end
    end

    // Queue pointers, occupancy and registered full flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (burst_end) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_next;
            full_q  <= (count_next == CntW'(AwQueueDepth));
        end
    end

    // Beat counter for the head burst; cleared when the burst closes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q <= '0;
        end else if (burst_end) begin
            beat_q <= '0;
        end else if (w_hs) begin
            beat_q <= beat_q + AxLenWidth'(1);
        end
    end

    // ---- stage p1: B response register, loaded one cycle after the final beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_vld_p1     <= 1'b0;
            b_id_p1      <= '0;
            b_content_p1 <= '0;
        end else if (burst_end) begin
            b_vld_p1     <= 1'b1;
            b_id_p1      <= head_id;
            b_content_p1 <= resp_content(w_last_i, at_len);
        end else if (b_hs) begin
            b_vld_p1     <= 1'b0;
            b_id_p1      <= '0;
            b_content_p1 <= '0;
        end
    end

endmodule

// File: tb/tb_simmem_write_responder.sv
// Bench for simmem_write_responder: table of bursts plus directed sequences
// for the full-queue, back-pressure and mid-burst reset corners. Expected B
// responses are queued when the AW is driven and popped when B handshakes.
module tb_simmem_write_responder;

    logic       clk;
    logic       rst_ni;
    logic       aw_valid;
    logic       aw_ready;
    logic [3:0] aw_id;
    logic [7:0] aw_len;
    logic       w_valid;
    logic       w_ready;
    logic       w_last;
    logic       b_valid;
    logic       b_ready;
    logic [3:0] b_id;
    logic [2:0] b_content;

    simmem_write_responder dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .aw_valid_i  (aw_valid),
        .aw_ready_o  (aw_ready),
        .aw_id_i     (aw_id),
        .aw_len_i    (aw_len),
        .w_valid_i   (w_valid),
        .w_ready_o   (w_ready),
        .w_last_i    (w_last),
        .b_valid_o   (b_valid),
        .b_ready_i   (b_ready),
        .b_id_o      (b_id),
        .b_content_o (b_content)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] id;
        logic [2:0] content;
    } resp_t;

    typedef struct {
        logic [3:0] id;
        logic [7:0] len;
        int         nbeats;
        int         last_beat;
        logic [2:0] exp_content;
    } vec_t;

    resp_t sb_q[$];
    vec_t  vecs[8];
    int    checks = 0;
    int    passes = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drive one AW request; the expected B for it goes onto the scoreboard.
    task automatic do_aw(input logic [3:0] id, input logic [7:0] len, input logic [2:0] exp_c);
        resp_t r;
        int n;
        aw_valid = 1'b1;
        aw_id    = id;
        aw_len   = len;
        n = 0;
        @(negedge clk);
        while (!aw_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("aw_accept", aw_ready, 1);
        sync();
        aw_valid = 1'b0;
        r.id = id;
        r.content = exp_c;
        sb_q.push_back(r);
    endtask

    // Drive one W beat and wait (bounded) for its handshake.
    task automatic do_w(input logic last, input logic bready);
        int n;
        w_valid = 1'b1;
        w_last  = last;
        b_ready = bready;
        n = 0;
        @(negedge clk);
        while (!w_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("w_accept", w_ready, 1);
        sync();
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_aw_ready"}, aw_ready, 1);
        check({tag, "_w_ready"}, w_ready, 0);
        check({tag, "_b_valid"}, b_valid, 0);
        check({tag, "_b_id"}, b_id, 0);
        check({tag, "_b_content"}, b_content, 0);
    endtask

    // Scoreboard: every B handshake must match the oldest outstanding AW.
    always @(negedge clk) begin
        if (rst_ni && b_valid && b_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL b_unexpected: got id %0h content %0h expected no response", b_id, b_content);
            end else begin
                resp_t e;
                e = sb_q.pop_front();
                check("b_id", b_id, e.id);
                check("b_content", b_content, e.content);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        vecs[0] = '{4'd3,  8'd0, 1, 0,  3'd0};
        vecs[1] = '{4'd5,  8'd3, 4, 3,  3'd0};
        vecs[2] = '{4'd7,  8'd3, 2, 1,  3'd2};
        vecs[3] = '{4'd1,  8'd0, 1, 0,  3'd0};
        vecs[4] = '{4'd2,  8'd1, 2, -1, 3'd2};
        vecs[5] = '{4'd15, 8'd7, 8, 7,  3'd0};
        vecs[6] = '{4'd9,  8'd2, 1, 0,  3'd2};
        vecs[7] = '{4'd0,  8'd0, 1, -1, 3'd2};

        rst_ni   = 1'b0;
        aw_valid = 1'b0;
        aw_id    = '0;
        aw_len   = '0;
        w_valid  = 1'b0;
        w_last   = 1'b0;
        b_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_ni = 1'b1;
        sync();

        // Table-driven bursts
        for (int v = 0; v < 8; v++) begin
            do_aw(vecs[v].id, vecs[v].len, vecs[v].exp_content);
            for (int b = 0; b < vecs[v].nbeats; b++) begin
                do_w(b == vecs[v].last_beat, 1'b1);
            end
            @(negedge clk);
            check("b_valid_lat", b_valid, 1);
            @(negedge clk);
            check("b_valid_clear", b_valid, 0);
            check("w_ready_idle", w_ready, 0);
            sync();
        end

        // Fill the AW queue, then pop one with an AW offered in the pop cycle
        for (int i = 0; i < 4; i++) begin
            do_aw(4'(10 + i), 8'd0, 3'd0);
        end
        @(negedge clk);
        check("aw_full", aw_ready, 0);
        sync();
        w_valid  = 1'b1;
        w_last   = 1'b1;
        b_ready  = 1'b1;
        aw_valid = 1'b1;
        aw_id    = 4'd14;
        aw_len   = 8'd0;
        @(negedge clk);
        check("aw_ready_pop_cycle", aw_ready, 0);
        check("w_ready_pop_cycle", w_ready, 1);
        sync();
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        w_last   = 1'b0;
        @(negedge clk);
        check("aw_ready_after_pop", aw_ready, 1);
        sync();
        for (int i = 0; i < 3; i++) begin
            do_w(1'b1, 1'b1);
        end
        @(negedge clk);
        check("no_phantom_push", w_ready, 0);
        sync();

        // B back-pressure blocks further beats and holds B stable
        do_aw(4'd6, 8'd1, 3'd2);
        do_w(1'b1, 1'b0);
        do_aw(4'd4, 8'd1, 3'd0);
        w_valid = 1'b1;
        w_last  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("w_ready_bp", w_ready, 0);
            check("b_valid_bp", b_valid, 1);
            check("b_id_bp", b_id, 6);
            check("b_content_bp", b_content, 2);
            sync();
        end
        b_ready = 1'b1;
        @(negedge clk);
        check("w_ready_release", w_ready, 1);
        sync();
        w_valid = 1'b0;
        do_w(1'b1, 1'b1);
        @(negedge clk);
        sync();

        // Reset mid-burst with a partial beat count and a full AW queue
        do_aw(4'd8, 8'd3, 3'd0);
        do_w(1'b0, 1'b1);
        do_w(1'b0, 1'b1);
        do_aw(4'd9, 8'd0, 3'd0);
        do_aw(4'd10, 8'd0, 3'd0);
        do_aw(4'd11, 8'd0, 3'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        sb_q.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        sync();
        do_aw(4'd12, 8'd3, 3'd0);
        for (int b = 0; b < 4; b++) begin
            do_w(b == 3, 1'b1);
        end
        @(negedge clk);
        check("b_valid_post_rst", b_valid, 1);
        sync();

        // Reset with an unconsumed B response
        do_aw(4'd3, 8'd1, 3'd2);
        do_w(1'b1, 1'b0);
        @(negedge clk);
        check("b_pending_pre_rst", b_valid, 1);
        #1;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("rst_b");
        sb_q.delete();
        @(negedge clk);
        rst_ni  = 1'b1;
        b_ready = 1'b1;
        sync();
        repeat (2) sync();
        check("sb_drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/simmem_write_responder.md
Name: simmem_write_responder

Overview:
- Slave-side AXI write responder for the simulated memory.
- Accepts write address requests (id, burst length) and write data beats, and counts beats per burst.
- Emits one write response per completed burst in address-acceptance order.
- Closes the write path opposite the initiator side; its response fields match write_resp_t (id, content).

Parameters:
IDWidth, 4, AXI ID width
AxLenWidth, 8, AW burst length field width (beats = len+1)
XRespWidth, 3, B response content width
AwQueueDepth, 4, pending AW entries (power of two, >=2)
RespOkay, 0, content value for a well-formed burst
RespSlvErr, 2, content value for a length/last mismatch

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
aw_valid_i  in  1  AW request valid
aw_ready_o  out  1  AW request ready
aw_id_i  in  IDWidth  AW id
aw_len_i  in  AxLenWidth  AW burst length (beats-1)
w_valid_i  in  1  W beat valid
w_ready_o  out  1  W beat ready
w_last_i  in  1  W last flag
b_valid_o  out  1  B response valid
b_ready_i  in  1  B response ready
b_id_o  out  IDWidth  B id
b_content_o  out  XRespWidth  B response content

Behaviour:
- Reset (rst_ni low, asynchronous): AW FIFO empty, pointers 0, beat counter 0, B register cleared.
  - aw_ready_o=1 after reset, w_ready_o=0, b_valid_o=0, b_id_o=0, b_content_o=0.
  - Reset mid-burst discards all pending AW entries, partial beat counts and any unconsumed B.
- AW FIFO: depth AwQueueDepth; each entry stores {id, len}.
  - aw_ready_o = !full (registered full flag).
  - A push occurs on aw_valid_i && aw_ready_o.
  - A pop freeing a slot in the same cycle does not raise aw_ready_o that cycle; there is no combinational pass-through.
  - Pointer wrap modulo AwQueueDepth.
  - Full/empty are tracked with an occupancy counter of width $clog2(AwQueueDepth)+1.
- W acceptance: w_ready_o = !empty && (!b_valid_o || b_ready_i).
  - W data is never stored; only handshakes are counted.
  - W beats are never accepted with no AW pending. Earliest W acceptance is the cycle after the AW push into an empty FIFO.
- Beat counter beat_q, AxLenWidth bits, counts accepted beats of the head burst.
  - On a W handshake, the burst ends if w_last_i==1 or beat_q==head.len.
  - Not ending: beat_q increments.
  - Ending: beat_q<=0, pop the head, load the B register.
  - beat_q never wraps because the burst ends no later than beat len.
- Response content:
  - RespOkay iff w_last_i==1 and beat_q==head.len on the same beat.
  - Otherwise RespSlvErr: early last, or missing last on the final beat.
  - b_id_o = head.id.
- B register:
  - Loaded with b_valid_o=1 the cycle after the final W handshake; latency is 1 cycle.
  - Holds id/content stable while b_valid_o && !b_ready_i.
  - Cleared on handshake, unless a new load occurs in the same cycle, in which case the new value replaces it and b_valid_o stays 1.
- Simultaneous AW push and head pop: both take effect; occupancy is unchanged.
- Ordering: responses are in AW acceptance order regardless of id.

Test Plan:
- Reset, then AW id=3 len=0, one W with last=1 and b_ready=1 -> b_valid=1 one cycle after the W handshake, b_id=3, b_content=0; then b_valid=0.
- AW id=5 len=3, four W beats with last only on the 4th -> exactly one B, id=5, content=0, after the 4th beat; w_ready=0 before the AW is accepted.
- AW len=3, W last=1 on beat 2 -> B content=2 after beat 2. A following AW id=1 len=0 with a good beat -> B id=1 content=0.
- AW len=1, two beats with last=0 -> B content=2 after beat 2.
- Push 4 AWs with no W -> aw_ready=0 after the 4th; then one single-beat burst completes -> aw_ready=1 on the following cycle, not the same cycle.
- Hold b_ready=0 with B pending, send the next burst's beats -> w_ready=0 on all beats; B id/content stable until b_ready=1. Assert rst_ni low mid-burst -> all outputs return to reset values immediately.
